// File: rtl/frame_cmd_scheduler.sv
// Frame command scheduler: FIFOs host sprite words into the back buffer and
// swaps buffers only in vblank. Optional stats ports under SCHED_STATS_EN.
module frame_cmd_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int V_ACTIVE   = 480,
  parameter int V_TOTAL    = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_data,
  output logic        cmd_ready,
  input  logic        commit_req,
  output logic        commit_ready,
  input  logic [9:0]  vcount,
  output logic [31:0] writedata,
  output logic        front_buf,
  output logic [15:0] frame_count
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0] miss_count,
  output logic        ovf_seen
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [9:0] VA = 10'(V_ACTIVE);
  localparam logic [9:0] VT = 10'(V_TOTAL);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_ARMED,
    S_FLUSH
  } state_e;

  state_e      state_q;
  logic [26:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rptr_q;
  logic [AW-1:0] wptr_q;
  logic [AW:0] cnt_q;
  logic [AW:0] cnt_d;
  logic [AW:0] pend_q;
  logic [31:0] wd_q;
  logic        front_q;
  logic [15:0] frame_q;
  logic        cr_q;
  logic        fvb_q;

  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        in_vblank;
  logic        commit_acc;
  logic [26:0] head;
  logic [31:0] issue_w;
  logic [31:0] flush_w;
  logic        unused_bits;

  // info and pp fields of host words are regenerated, never stored
  assign unused_bits = ^{cmd_data[20:17], cmd_data[13]};

  assign full       = (cnt_q == FULL_CNT);
  assign empty      = (cnt_q == '0);
  assign cmd_ready  = !full;
  assign push       = cmd_valid && !full;
  assign in_vblank  = (vcount >= VA) && (vcount < VT);
  assign commit_acc = commit_req && cr_q && (state_q == S_IDLE);

  assign head    = mem[rptr_q];
  assign issue_w = {head[26:16], 4'b0001, head[15:13],
                    ~front_q, head[12:0]};
  assign flush_w = {11'd0, 4'b1111, 3'd0, ~front_q, 13'd0};

  always_comb begin
    pop = 1'b0;
    case (state_q)
      S_IDLE:  pop = !empty;
      S_DRAIN: pop = (pend_q != '0);
      default: pop = 1'b0;
    endcase
  end

  assign cnt_d = cnt_q
               + {{AW{1'b0}}, push}
               - {{AW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr_q] <= {cmd_data[31:21],
                      cmd_data[16:14],
                      cmd_data[12:0]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rptr_q  <= '0;
      wptr_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
      wd_q    <= 32'h0;
      front_q <= 1'b0;
      frame_q <= 16'h0;
      cr_q    <= 1'b1;
      fvb_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= wptr_q + PTR_ONE;
      if (pop)  rptr_q <= rptr_q + PTR_ONE;
      wd_q <= pop ? issue_w : 32'h0;
      if (vcount == 10'd0) fvb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (commit_acc) begin
            cr_q    <= 1'b0;
            pend_q  <= cnt_d;
            state_q <= (cnt_d == '0) ? S_ARMED : S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pend_q != '0) pend_q <= pend_q - CNT_ONE;
          if (pend_q <= CNT_ONE) state_q <= S_ARMED;
        end
        S_ARMED: begin
          if (in_vblank && !fvb_q) begin
            wd_q    <= flush_w;
            front_q <= ~front_q;
            frame_q <= frame_q + 16'd1;
            fvb_q   <= 1'b1;
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          cr_q    <= 1'b1;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign writedata    = wd_q;
  assign front_buf    = front_q;
  assign frame_count  = frame_q;
  assign commit_ready = cr_q;

`ifdef SCHED_STATS_EN
  logic [15:0] miss_q;
  logic        ovf_q;
  logic        vb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      miss_q <= 16'h0;
      ovf_q  <= 1'b0;
      vb_q   <= 1'b0;
    end else begin
      vb_q <= in_vblank;
      if (cmd_valid && !cmd_ready) ovf_q <= 1'b1;
      if (vb_q && !in_vblank && !cr_q && (miss_q != 16'hFFFF))
        miss_q <= miss_q + 16'd1;
    end
  end

  assign miss_count = miss_q;
  assign ovf_seen   = ovf_q;
`endif

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// Randomized scoreboard bench for frame_cmd_scheduler with a queue-based
// frame model; stats ports are checked when SCHED_STATS_EN is defined.
module tb_frame_cmd_scheduler;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [31:0] cmd_data = 32'h0;
  logic        cmd_ready;
  logic        commit_req = 1'b0;
  logic        commit_ready;
  logic [9:0]  vcount = 10'd0;
  logic [31:0] writedata;
  logic        front_buf;
  logic [15:0] frame_count;
`ifdef SCHED_STATS_EN
  logic [15:0] miss_count;
  logic        ovf_seen;
`endif

  frame_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .V_ACTIVE(480),
    .V_TOTAL(525)
  ) dut (
    .clk(clk),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .commit_req(commit_req),
    .commit_ready(commit_ready),
    .vcount(vcount),
    .writedata(writedata),
    .front_buf(front_buf),
    .frame_count(frame_count)
`ifdef SCHED_STATS_EN
    ,
    .miss_count(miss_count),
    .ovf_seen(ovf_seen)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t sbq[$];
  int compared = 0;
  int mismatched = 0;

  logic [31:0] m_q[$];
  int          m_pend = 0;
  bit          m_committed = 0;
  bit          m_flush_out = 0;
  bit          m_front = 0;
  bit          m_fvb = 0;
  bit          m_prev_vb = 0;
  bit          m_ovf = 0;
  logic [15:0] m_frame = 0;
  logic [15:0] m_miss = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: every non-idle bus word must match the scoreboard head in
  // both value and cycle; an expected word that never shows also fails
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (sbq.size() > 0 && sbq[0].c <= cyc) begin
        compared++;
        if (writedata !== sbq[0].d || sbq[0].c != cyc) begin
          mismatched++;
          $display("FAIL writedata: got %h expected %h (cycle %0d, due %0d)",
                   writedata, sbq[0].d, cyc, sbq[0].c);
        end
        void'(sbq.pop_front());
      end else if (writedata !== 32'h0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_word: got %h expected 00000000 (cycle %0d)",
                 writedata, cyc);
      end
    end
  end

  function automatic void expect_word(input logic [31:0] w);
    exp_t e;
    e.d = w;
    e.c = cyc + 1;
    sbq.push_back(e);
  endfunction

  task automatic model_reset();
    m_q.delete();
    sbq.delete();
    m_pend = 0;
    m_committed = 0;
    m_flush_out = 0;
    m_front = 0;
    m_fvb = 0;
    m_prev_vb = 0;
    m_ovf = 0;
    m_frame = 0;
    m_miss = 0;
  endtask

  task automatic step(input logic v, input logic [31:0] d,
                      input logic cm, input logic [9:0] vc);
    bit push;
    bit pop;
    bit vb;
    logic [31:0] h;
    @(negedge clk);
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_q.size() < DEPTH});
    chk("commit_ready", {31'd0, commit_ready}, {31'd0, !m_committed});
    chk("front_buf", {31'd0, front_buf}, {31'd0, m_front});
    chk("frame_count", {16'd0, frame_count}, {16'd0, m_frame});
    cmd_valid = v;
    cmd_data = d;
    commit_req = cm;
    vcount = vc;
    push = v && (m_q.size() < DEPTH);
    pop = 0;
    if (v && !push) m_ovf = 1;
    vb = (vc >= 10'd480) && (vc < 10'd525);
    if (m_prev_vb && !vb && m_committed && m_miss != 16'hFFFF)
      m_miss++;
    m_prev_vb = vb;
    if (m_flush_out) begin
      m_flush_out = 0;
      m_committed = 0;
    end else if (!m_committed) begin
      pop = (m_q.size() > 0);
      if (cm) begin
        m_committed = 1;
        m_pend = m_q.size() + int'(push) - int'(pop);
      end
    end else if (m_pend > 0) begin
      pop = 1;
      m_pend--;
    end else if (vb && !m_fvb) begin
      expect_word({11'd0, 4'b1111, 3'd0, ~m_front, 13'd0});
      m_front = ~m_front;
      m_frame++;
      m_fvb = 1;
      m_flush_out = 1;
    end
    if (vc == 10'd0) m_fvb = 0;
    if (pop) begin
      h = m_q.pop_front();
      expect_word({h[31:21], 4'b0001, h[16:14], ~m_front, h[12:0]});
    end
    if (push) m_q.push_back(d);
  endtask

  task automatic idle(input int n, input logic [9:0] vc);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, vc);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    cmd_valid = 1'b0;
    commit_req = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_writedata", writedata, 32'h0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_commit_ready", {31'd0, commit_ready}, 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [9:0] rvc;
  int n;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_writedata", writedata, 32'h0);
    chk("reset_front_buf", {31'd0, front_buf}, 32'd0);
    chk("reset_frame_count", {16'd0, frame_count}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_commit_ready", {31'd0, commit_ready}, 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b1, $urandom, 1'b0, 10'd100);
    idle(4, 10'd100);

    step(1'b1, 32'hA5A5_0001, 1'b0, 10'd100);
    step(1'b1, 32'h5A5A_0002, 1'b1, 10'd100);
    step(1'b1, 32'hC3C3_0003, 1'b0, 10'd100);
    idle(6, 10'd100);
    idle(6, 10'd480);

    idle(1, 10'd0);
    step(1'b0, 32'h0, 1'b1, 10'd200);
    idle(6, 10'd200);
    idle(6, 10'd480);
    chk("frame_count_after_two", {16'd0, frame_count}, 32'd2);

    idle(1, 10'd0);
    step(1'b0, 32'h0, 1'b1, 10'd100);
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, $urandom, 1'b0, 10'd100);
    chk("full_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    idle(22, 10'd480);

    idle(1, 10'd0);
    step(1'b0, 32'h0, 1'b1, 10'd500);
    idle(4, 10'd500);
    step(1'b0, 32'h0, 1'b1, 10'd500);
    idle(10, 10'd500);
    idle(1, 10'd0);
    idle(4, 10'd480);

    idle(1, 10'd0);
    step(1'b0, 32'h0, 1'b1, 10'd100);
    for (int i = 0; i < 12; i++) step(1'b1, $urandom, 1'b0, 10'd100);
    step(1'b0, 32'h0, 1'b0, 10'd480);
    n = 0;
    while (m_committed && n < 20) begin
      step(1'b0, 32'h0, 1'b0, 10'd480);
      n++;
    end
    step(1'b0, 32'h0, 1'b1, 10'd480);
    idle(2, 10'd480);
    async_reset();
    idle(4, 10'd100);

    rvc = 10'($urandom_range(0, 524));
    for (int i = 0; i < 4000; i++) begin
      step(1'b0 + ($urandom_range(0, 99) < 55),
           $urandom,
           1'b0 + ($urandom_range(0, 99) < 3),
           rvc);
      rvc = (rvc + 10'($urandom_range(1, 4)) >= 10'd525)
          ? 10'd0 : rvc + 10'($urandom_range(1, 4));
    end

    n = 0;
    while ((m_committed || m_q.size() > 0 || m_flush_out) && n < 3000) begin
      step(1'b0, 32'h0, 1'b0, rvc);
      rvc = (rvc >= 10'd520) ? 10'd0 : rvc + 10'd4;
      n++;
    end
    chk("drain_done", {31'd0, n < 3000}, 32'd1);
    idle(3, 10'd100);
    chk("scoreboard_empty", sbq.size(), 32'd0);
`ifdef SCHED_STATS_EN
    chk("miss_count", {16'd0, miss_count}, {16'd0, m_miss});
    chk("ovf_seen", {31'd0, ovf_seen}, {31'd0, m_ovf});
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
